th_gate_array: RTL and testbench
================================

TH_GATE_ARRAY -- requirements
Module: th_gate_array

Interface
REQ-001 The block SHALL have parameter CH, default 4, giving the number of independent threshold-gate channels (1..32).
REQ-002 The block SHALL have parameter IN, default 3, giving the number of inputs per channel (2..8).
REQ-003 The block SHALL have parameter THR, default 2, giving the per-channel set threshold (1..W0+IN-1).
REQ-004 The block SHALL have parameter W0, default 1, giving the weight of input 0 of each channel (1..IN); all other inputs SHALL have weight 1.
REQ-005 The block SHALL have parameter CNT_W, default 8, giving the width of the wavefront counter.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 in  input  CH*IN  channel c inputs at in[c*IN +: IN]; in[c*IN] is the weighted input.
REQ-009 out  output  CH  registered hysteretic gate outputs, one per channel.
REQ-010 ko  output  1  completion acknowledge: 1 = request DATA, 0 = request NULL.
REQ-011 wave_cnt  output  CNT_W  count of completed DATA->NULL wavefronts.
REQ-012 err  output  1  sticky protocol-violation flag.

Function
REQ-013 Per channel: sum = W0*in[c*IN] + popcount(in[c*IN+1 +: IN-1]); the sum SHALL be computed at a width that cannot overflow.
REQ-014 Each out[c] SHALL update on every clk edge as follows: if sum >= THR, next = 1; else if all channel inputs are 0, next = 0; else hold.
REQ-015 Latency from input change to out SHALL be exactly 1 cycle.
REQ-016 A completion FSM SHALL observe the registered out vector and use the states NULL, FILL, DATA and DRAIN.
REQ-017 NULL->DATA SHALL occur when all outs are 1, and NULL->FILL when some but not all outs are 1.
REQ-018 FILL->DATA SHALL occur when all outs are 1, and FILL->NULL when all outs are 0.
REQ-019 DATA->NULL SHALL occur when all outs are 0, and DATA->DRAIN when some but not all outs are 0.
REQ-020 DRAIN->NULL SHALL occur when all outs are 0, and DRAIN->DATA when all outs are 1.
REQ-021 In all other cases the FSM SHALL hold its state.
REQ-022 ko SHALL be registered: it SHALL go to 0 on the edge entering DATA, go to 1 on the edge entering NULL, and hold otherwise, giving an input-to-ko latency of 2 cycles.
REQ-023 wave_cnt SHALL increment by 1 on every transition into NULL from DATA or DRAIN and SHALL wrap modulo 2^CNT_W.
REQ-024 A FILL->NULL transition SHALL NOT increment wave_cnt.
REQ-025 err SHALL set when any out bit goes 1->0 while in FILL (an incomplete DATA wave withdrawn).
REQ-026 err SHALL also set when any out bit goes 0->1 while in DRAIN (premature DATA).
REQ-027 Per REQ-025/026, if rising and falling bits occur on the same edge in FILL or DRAIN, err SHALL set and the FSM transition rules SHALL still apply.
REQ-028 Once set, err SHALL remain 1 until rst.
REQ-029 With CH=1, FILL and DRAIN SHALL be unreachable, and NULL<->DATA SHALL alternate directly.

Reset
REQ-030 While rst=1, out SHALL be 0, the FSM SHALL be in NULL, ko SHALL be 1, wave_cnt SHALL be 0 and err SHALL be 0, all immediately and without waiting for clk.
REQ-031 Reset asserted mid-wave SHALL discard all hysteresis state, and the first edge after deassertion SHALL evaluate the inputs as if from NULL.

Verification (CH=2, IN=3, THR=2, W0=2, CNT_W=2 unless noted)
REQ-032 The bench SHALL cover: rst=1 with in=6'b111111 -> out=00, ko=1, wave_cnt=0, err=0; after rst drops, out=11 one edge later.
REQ-033 The bench SHALL cover: in[0]=1 (sum 2) -> out[0]=1 after 1 edge, ko stays 1; then in[5:4]=11 -> out[1]=1 after 1 edge and ko=0 one edge after that.
REQ-034 The bench SHALL cover hysteresis: from DATA, in[5:3]=100 (sum 1) -> out[1] holds 1; in[5:3]=000 -> out[1]=0 and the state goes to DRAIN; clearing in[0] -> out=00, ko=1, wave_cnt=1.
REQ-035 The bench SHALL cover counter wrap: 4 complete DATA/NULL wavefronts -> wave_cnt reads 1,2,3,0.
REQ-036 The bench SHALL cover a protocol error: out[0]=1 in FILL, then in[2:0]=000 -> out[0]=0, state NULL, err=1 and held through further clean waves; wave_cnt unchanged.
REQ-037 The bench SHALL cover reset mid-DATA: assert rst between clock edges -> out=00, ko=1, wave_cnt=0, err=0 immediately.

Source files
------------

// File: rtl/th_gate_array.sv
`default_nettype none
// ============================================================================
//  Module   : th_gate_array
//  Purpose  : Array of CH hysteretic threshold gates (THmn style), one
//             weighted input per channel. A completion FSM watches the
//             registered gate outputs to generate ko, count DATA->NULL
//             wavefronts and flag protocol violations.
//  Revision : 1.0 - initial release
// ============================================================================
module th_gate_array #(
    parameter int CH    = 4,
    parameter int IN    = 3,
    parameter int THR   = 2,
    parameter int W0    = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH*IN-1:0] in,
    output logic [CH-1:0]    out,
    output logic             ko,
    output logic [CNT_W-1:0] wave_cnt,
    output logic             err
);

    // The largest sum is W0 + (IN-1); one extra bit keeps the compare safe.
    localparam int                 c_SUM_W = $clog2(W0 + IN) + 1;
    localparam logic [c_SUM_W-1:0] c_THR   = c_SUM_W'(THR);
    localparam logic [c_SUM_W-1:0] c_W0    = c_SUM_W'(W0);

    typedef enum logic [1:0] {
        S_NULL  = 2'd0,
        S_FILL  = 2'd1,
        S_DATA  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    logic [CH-1:0]    r_out;
    logic [CH-1:0]    r_out_q;     // out vector as last seen by the FSM
    logic [CH-1:0]    w_out_next;
    state_t           r_state;
    state_t           w_state_next;
    logic             r_ko;
    logic [CNT_W-1:0] r_wave_cnt;
    logic             r_err;

    logic             w_all1;
    logic             w_all0;
    logic             w_err_set;
    logic             w_enter_data;
    logic             w_enter_null;
    logic             w_wave_done;

    genvar g;
    generate
        for (g = 0; g < CH; g++) begin : g_ch
            logic [c_SUM_W-1:0] w_sum;

            // Weighted input sum for this channel.
            always_comb begin
                w_sum = in[g*IN] ? c_W0 : '0;
                for (int i = 1; i < IN; i++) begin
                    w_sum = w_sum + c_SUM_W'(in[g*IN+i]);
                end
            end

            // Set at threshold, clear only when every input is NULL, else hold.
            assign w_out_next[g] = (w_sum >= c_THR)     ? 1'b1 :
                                   (~|in[g*IN +: IN])   ? 1'b0 :
                                                          r_out[g];
        end
    endgenerate

    // Gate output registers plus the one-cycle history used for error checks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_out_q <= '0;
        end else begin
            r_out   <= w_out_next;
            r_out_q <= r_out;
        end
    end

    assign w_all1 = &r_out;
    assign w_all0 = ~|r_out;

    // Completion FSM next-state logic driven by the registered out vector.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_NULL: begin
                if (w_all1)       w_state_next = S_DATA;
                else if (!w_all0) w_state_next = S_FILL;
            end
            S_FILL: begin
                if (w_all1)       w_state_next = S_DATA;
                else if (w_all0)  w_state_next = S_NULL;
            end
            S_DATA: begin
                if (w_all0)       w_state_next = S_NULL;
                else if (!w_all1) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_all0)       w_state_next = S_NULL;
                else if (w_all1)  w_state_next = S_DATA;
            end
            default:              w_state_next = S_NULL;
        endcase
    end

    // A withdrawn bit while filling, or a new bit while draining, is a violation.
    assign w_err_set = ((r_state == S_FILL)  && |(r_out_q & ~r_out)) ||
                       ((r_state == S_DRAIN) && |(~r_out_q & r_out));

    assign w_enter_data = (w_state_next == S_DATA) && (r_state != S_DATA);
    assign w_enter_null = (w_state_next == S_NULL) && (r_state != S_NULL);
    assign w_wave_done  = (w_state_next == S_NULL) &&
                          ((r_state == S_DATA) || (r_state == S_DRAIN));

    // State, ko, wavefront counter and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_NULL;
            r_ko       <= 1'b1;
            r_wave_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_enter_data)      r_ko <= 1'b0;
            else if (w_enter_null) r_ko <= 1'b1;
            if (w_wave_done)       r_wave_cnt <= r_wave_cnt + CNT_W'(1);
            if (w_err_set)         r_err <= 1'b1;
        end
    end

    assign out      = r_out;
    assign ko       = r_ko;
    assign wave_cnt = r_wave_cnt;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_th_gate_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_th_gate_array
//  Purpose  : Scoreboard bench for th_gate_array (CH=2, IN=3, THR=2, W0=2,
//             CNT_W=2). Stimulus queues expected outputs tagged with the
//             cycle they apply to; a monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_th_gate_array;

    logic       clk;
    logic       rst;
    logic [5:0] in_v;
    logic [1:0] out_v;
    logic       ko;
    logic [1:0] wave_cnt;
    logic       err;

    th_gate_array #(
        .CH    (2),
        .IN    (3),
        .THR   (2),
        .W0    (2),
        .CNT_W (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in_v),
        .out      (out_v),
        .ko       (ko),
        .wave_cnt (wave_cnt),
        .err      (err)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [1:0] out;
        logic       ko;
        logic [1:0] wc;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    event chk_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose cycle has been reached.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                if (out_v !== e.out || ko !== e.ko || wave_cnt !== e.wc || err !== e.err) begin
                    errors++;
                    $display("FAIL %s: got out=%b ko=%b wave_cnt=%0d err=%b, expected out=%b ko=%b wave_cnt=%0d err=%b",
                             e.name, out_v, ko, wave_cnt, err, e.out, e.ko, e.wc, e.err);
                end
            end
        end
    end

    task automatic expect_at(input int d, input string n, input logic [1:0] o,
                             input logic k, input logic [1:0] w, input logic er);
        exp_t e;
        e.cyc  = cyc + d;
        e.name = n;
        e.out  = o;
        e.ko   = k;
        e.wc   = w;
        e.err  = er;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check immediately, then release with in=0.
    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        expect_at(0, "rst_immediate", 2'b00, 1'b1, 2'd0, 1'b0);
        ->chk_ev;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        in_v = 6'b000000;
        expect_at(1, "rst_release", 2'b00, 1'b1, 2'd0, 1'b0);
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] wrap_exp[4];
        logic [1:0] prev;
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0};

        // Reset with all inputs asserted: outputs held at reset values.
        rst  = 1'b1;
        in_v = 6'b111111;
        #2;
        expect_at(0, "rst_async", 2'b00, 1'b1, 2'd0, 1'b0);
        ->chk_ev;
        @(posedge clk);
        #1;
        expect_at(1, "rst_hold", 2'b00, 1'b1, 2'd0, 1'b0);
        step(1);
        rst = 1'b0;
        expect_at(1, "rel_out", 2'b11, 1'b1, 2'd0, 1'b0);
        expect_at(2, "rel_ko",  2'b11, 1'b0, 2'd0, 1'b0);
        step(2);
        in_v = 6'b000000;
        expect_at(1, "s1_drop", 2'b00, 1'b0, 2'd0, 1'b0);
        expect_at(2, "s1_null", 2'b00, 1'b1, 2'd1, 1'b0);
        step(2);

        // Weighted input alone reaches threshold; channel 1 completes the wave.
        in_v = 6'b000001;
        expect_at(1, "fill_out", 2'b01, 1'b1, 2'd1, 1'b0);
        expect_at(2, "fill_ko",  2'b01, 1'b1, 2'd1, 1'b0);
        step(2);
        in_v = 6'b110001;
        expect_at(1, "data_out", 2'b11, 1'b1, 2'd1, 1'b0);
        expect_at(2, "data_ko",  2'b11, 1'b0, 2'd1, 1'b0);
        step(2);

        // Hysteresis: sum 1 holds, all-zero clears, then drain to NULL.
        in_v = 6'b100001;
        expect_at(1, "hyst_hold", 2'b11, 1'b0, 2'd1, 1'b0);
        step(1);
        in_v = 6'b000001;
        expect_at(1, "drain_out", 2'b01, 1'b0, 2'd1, 1'b0);
        expect_at(2, "drain_ko",  2'b01, 1'b0, 2'd1, 1'b0);
        step(2);
        in_v = 6'b000000;
        expect_at(1, "drain_clr",  2'b00, 1'b0, 2'd1, 1'b0);
        expect_at(2, "drain_null", 2'b00, 1'b1, 2'd2, 1'b0);
        step(2);

        // Counter wrap over four full wavefronts.
        do_reset();
        prev = 2'd0;
        for (int k = 0; k < 4; k++) begin
            in_v = 6'b111111;
            expect_at(1, "wrap_out",  2'b11, 1'b1, prev, 1'b0);
            expect_at(2, "wrap_data", 2'b11, 1'b0, prev, 1'b0);
            step(2);
            in_v = 6'b000000;
            expect_at(1, "wrap_drop", 2'b00, 1'b0, prev, 1'b0);
            expect_at(2, "wrap_cnt",  2'b00, 1'b1, wrap_exp[k], 1'b0);
            step(2);
            prev = wrap_exp[k];
        end

        // Protocol error: partial DATA withdrawn while filling.
        in_v = 6'b000001;
        expect_at(1, "perr_out",  2'b01, 1'b1, 2'd0, 1'b0);
        expect_at(2, "perr_fill", 2'b01, 1'b1, 2'd0, 1'b0);
        step(2);
        in_v = 6'b000000;
        expect_at(1, "perr_drop", 2'b00, 1'b1, 2'd0, 1'b0);
        expect_at(2, "perr_set",  2'b00, 1'b1, 2'd0, 1'b1);
        step(2);
        in_v = 6'b111111;
        expect_at(1, "perr_sticky_out",  2'b11, 1'b1, 2'd0, 1'b1);
        expect_at(2, "perr_sticky_data", 2'b11, 1'b0, 2'd0, 1'b1);
        step(2);
        in_v = 6'b000000;
        expect_at(1, "perr_sticky_drop", 2'b00, 1'b0, 2'd0, 1'b1);
        expect_at(2, "perr_sticky_null", 2'b00, 1'b1, 2'd1, 1'b1);
        step(2);

        // Reset in the middle of a DATA wave.
        in_v = 6'b111111;
        expect_at(1, "mid_out",  2'b11, 1'b1, 2'd1, 1'b1);
        expect_at(2, "mid_data", 2'b11, 1'b0, 2'd1, 1'b1);
        step(2);
        do_reset();

        step(3);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
